// File: rtl/aludec_pipe_if.sv
// aludec_pipe_if: decode-stage handshake and control bundle for aludec_pipe.
//   master: drives in_valid/aluop/funct3/funct7/out_ready, observes the rest
//   slave : the decoder stage, drives in_ready/out_valid and decoded controls
interface aludec_pipe_if;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] aluop;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] alucontrol;
   logic [1:0] shtype;
   logic       alu2src;
   logic       sltunsigned;
   logic       lh;
   logic       lb;
   logic       lhu;
   logic       lbu;
   logic       muldiv;
   logic [2:0] mdop;
   logic       illegal;
   modport master (
      output in_valid, aluop, funct3, funct7, out_ready,
      input  in_ready, out_valid, alucontrol, shtype, alu2src, sltunsigned,
             lh, lb, lhu, lbu, muldiv, mdop, illegal
   );
   modport slave (
      input  in_valid, aluop, funct3, funct7, out_ready,
      output in_ready, out_valid, alucontrol, shtype, alu2src, sltunsigned,
             lh, lb, lhu, lbu, muldiv, mdop, illegal
   );
endinterface

// File: rtl/aludec_pipe.sv
// aludec_pipe: registered valid/ready ALU decoder between decode and execute.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : aludec_pipe_if.slave -- in_valid/in_ready + aluop/funct3/funct7 in,
//             out_valid/out_ready + alucontrol/shtype/alu2src/sltunsigned/
//             lh/lb/lhu/lbu/muldiv/mdop/illegal out
//   ENABLE_M   : 1 decodes RV32M, 0 flags it illegal
//   MULDIV_LAT : accept-to-out_valid latency of an M op (1..15)
module aludec_pipe #(
   parameter bit          ENABLE_M   = 1'b1,
   parameter int unsigned MULDIV_LAT = 4
) (
   input logic         clk,
   input logic         reset_n,
   aludec_pipe_if.slave bus
);
   typedef struct packed {
      logic [3:0] alucontrol;
      logic [1:0] shtype;
      logic       alu2src;
      logic       sltunsigned;
      logic       lh;
      logic       lb;
      logic       lhu;
      logic       lbu;
      logic       muldiv;
      logic [2:0] mdop;
      logic       illegal;
   } ctl_t;
   typedef enum logic [1:0] {EMPTY, FULL, WAIT} state_t;
   localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);
   localparam logic [6:0] F7_ALT = 7'b0100000;
   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   ctl_t       dec, q;
   logic       accept;
   // funct3 mapping shared by OP-IMM and OP with funct7=0; for OP-IMM the
   // funct7 field is imm[11:5] and only matters for the shifts
   function automatic ctl_t base_dec(input logic [2:0] f3, input logic [6:0] f7);
      ctl_t c;
      c = '0;
      case (f3)
         3'b000: c.alucontrol = 4'b0010;
         3'b001: begin
            c.alucontrol = 4'b0010;
            c.alu2src    = f7 == 7'd0;
            c.illegal    = f7 != 7'd0;
         end
         3'b010: c.alucontrol = 4'b0111;
         3'b011: begin
            c.alucontrol  = 4'b0111;
            c.sltunsigned = 1'b1;
         end
         3'b100: c.alucontrol = 4'b1000;
         3'b101: begin
            c.alucontrol = 4'b0010;
            c.alu2src    = 1'b1;
            c.shtype     = f7 == 7'd0 ? 2'b01 : f7 == F7_ALT ? 2'b10 : 2'b00;
            c.illegal    = f7 != 7'd0 && f7 != F7_ALT;
         end
         3'b110: c.alucontrol = 4'b0001;
         default: c.alucontrol = 4'b0000;
      endcase
      return c;
   endfunction
   always_comb begin
      dec = '0;
      case (bus.aluop)
         3'b000: dec = base_dec(bus.funct3, bus.funct7);
         3'b100: begin
            dec.illegal    = bus.funct3 == 3'b011 || bus.funct3[2:1] == 2'b11;
            dec.alucontrol = dec.illegal ? 4'b0000 : 4'b0010;
            dec.lb         = bus.funct3 == 3'b000 || bus.funct3 == 3'b100;
            dec.lh         = bus.funct3 == 3'b001 || bus.funct3 == 3'b101;
            dec.lbu        = bus.funct3 == 3'b100;
            dec.lhu        = bus.funct3 == 3'b101;
         end
         3'b010: begin
            if (bus.funct7 == 7'd0) begin
               dec = base_dec(bus.funct3, bus.funct7);
            end else if (bus.funct7 == F7_ALT) begin
               dec.alucontrol = bus.funct3 == 3'b000 ? 4'b0110 :
                                bus.funct3 == 3'b101 ? 4'b0010 : 4'b0000;
               dec.alu2src    = bus.funct3 == 3'b101;
               dec.shtype     = bus.funct3 == 3'b101 ? 2'b10 : 2'b00;
               dec.illegal    = bus.funct3 != 3'b000 && bus.funct3 != 3'b101;
            end else if (bus.funct7 == 7'b0000001 && ENABLE_M) begin
               dec.muldiv = 1'b1;
               dec.mdop   = bus.funct3;
            end else begin
               dec.illegal = 1'b1;
            end
         end
         default: dec = '0;
      endcase
   end
   assign bus.out_valid = state == FULL;
   assign bus.in_ready  = state != WAIT && (!bus.out_valid || bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (state == WAIT) begin
         cnt_nx = cnt - 4'd1;
         if (cnt == 4'd1) state_nx = FULL;
      end else if (accept) begin
         if (dec.muldiv && MULDIV_LAT > 1) begin
            state_nx = WAIT;
            cnt_nx   = LAT_M1;
         end else begin
            state_nx = FULL;
         end
      end else if (state == FULL && bus.out_ready) begin
         state_nx = EMPTY;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= EMPTY;
         cnt   <= 4'd0;
         q     <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) q <= dec;
      end
   end
   assign bus.alucontrol  = q.alucontrol;
   assign bus.shtype      = q.shtype;
   assign bus.alu2src     = q.alu2src;
   assign bus.sltunsigned = q.sltunsigned;
   assign bus.lh          = q.lh;
   assign bus.lb          = q.lb;
   assign bus.lhu         = q.lhu;
   assign bus.lbu         = q.lbu;
   assign bus.muldiv      = q.muldiv;
   assign bus.mdop        = q.mdop;
   assign bus.illegal     = q.illegal;
endmodule

// File: tb/tb_aludec_pipe.sv
// tb_aludec_pipe: checks three aludec_pipe instances (M with latency 4,
// no M, M with latency 1) against a time-based behavioural model, plus
// hand-computed literal expectations for the directed scenarios.
module tb_aludec_pipe;
   typedef struct packed {
      bit [3:0] ac;
      bit [1:0] sh;
      bit       a2, su, lh, lb, lhu, lbu, md;
      bit [2:0] mdop;
      bit       il;
   } ctl_t;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic [2:0] aluop = 3'd0;
   logic [2:0] funct3 = 3'd0;
   logic [6:0] funct7 = 7'd0;
   always #5 clk = ~clk;
   aludec_pipe_if ifm ();
   aludec_pipe_if ifn ();
   aludec_pipe_if ifo ();
   assign ifm.in_valid = in_valid;
   assign ifm.out_ready = out_ready;
   assign ifm.aluop = aluop;
   assign ifm.funct3 = funct3;
   assign ifm.funct7 = funct7;
   assign ifn.in_valid = in_valid;
   assign ifn.out_ready = out_ready;
   assign ifn.aluop = aluop;
   assign ifn.funct3 = funct3;
   assign ifn.funct7 = funct7;
   assign ifo.in_valid = in_valid;
   assign ifo.out_ready = out_ready;
   assign ifo.aluop = aluop;
   assign ifo.funct3 = funct3;
   assign ifo.funct7 = funct7;
   aludec_pipe #(.ENABLE_M(1'b1), .MULDIV_LAT(4)) dut_m (.clk(clk), .reset_n(reset_n), .bus(ifm));
   aludec_pipe #(.ENABLE_M(1'b0), .MULDIV_LAT(4)) dut_n (.clk(clk), .reset_n(reset_n), .bus(ifn));
   aludec_pipe #(.ENABLE_M(1'b1), .MULDIV_LAT(1)) dut_o (.clk(clk), .reset_n(reset_n), .bus(ifo));
   logic        act_ov [3];
   logic        act_ir [3];
   logic [16:0] act_c  [3];
   assign act_ov[0] = ifm.out_valid;
   assign act_ov[1] = ifn.out_valid;
   assign act_ov[2] = ifo.out_valid;
   assign act_ir[0] = ifm.in_ready;
   assign act_ir[1] = ifn.in_ready;
   assign act_ir[2] = ifo.in_ready;
   assign act_c[0] = {ifm.alucontrol, ifm.shtype, ifm.alu2src, ifm.sltunsigned, ifm.lh, ifm.lb,
                      ifm.lhu, ifm.lbu, ifm.muldiv, ifm.mdop, ifm.illegal};
   assign act_c[1] = {ifn.alucontrol, ifn.shtype, ifn.alu2src, ifn.sltunsigned, ifn.lh, ifn.lb,
                      ifn.lhu, ifn.lbu, ifn.muldiv, ifn.mdop, ifn.illegal};
   assign act_c[2] = {ifo.alucontrol, ifo.shtype, ifo.alu2src, ifo.sltunsigned, ifo.lh, ifo.lb,
                      ifo.lhu, ifo.lbu, ifo.muldiv, ifo.mdop, ifo.illegal};
   function automatic bit en_of(input int d);
      return d != 1;
   endfunction
   function automatic int lat_of(input int d);
      return d == 2 ? 1 : 4;
   endfunction
   // decode rules written as a table lookup plus exceptions
   function automatic ctl_t model_dec(input bit en, input logic [2:0] op, input logic [2:0] f3,
                                      input logic [6:0] f7);
      ctl_t     r;
      bit [3:0] ac_of [8];
      r = '0;
      ac_of = '{4'b0010, 4'b0010, 4'b0111, 4'b0111, 4'b1000, 4'b0010, 4'b0001, 4'b0000};
      if (op == 3'b100) begin
         if (f3 == 3'd3 || f3 >= 3'd6) r.il = 1'b1;
         else begin
            r.ac  = 4'b0010;
            r.lb  = f3 == 3'd0 || f3 == 3'd4;
            r.lh  = f3 == 3'd1 || f3 == 3'd5;
            r.lbu = f3 == 3'd4;
            r.lhu = f3 == 3'd5;
         end
      end else if (op == 3'b000 || (op == 3'b010 && f7 == 7'd0)) begin
         r.ac = ac_of[f3];
         r.su = f3 == 3'd3;
         if (f3 == 3'd1) begin
            r.a2 = f7 == 7'd0;
            r.il = f7 != 7'd0;
         end
         if (f3 == 3'd5) begin
            r.a2 = 1'b1;
            r.sh = f7 == 7'd0 ? 2'd1 : f7 == 7'h20 ? 2'd2 : 2'd0;
            r.il = f7 != 7'd0 && f7 != 7'h20;
         end
      end else if (op == 3'b010 && f7 == 7'h20) begin
         if (f3 == 3'd0) r.ac = 4'b0110;
         else if (f3 == 3'd5) begin
            r.ac = 4'b0010;
            r.a2 = 1'b1;
            r.sh = 2'd2;
         end else r.il = 1'b1;
      end else if (op == 3'b010 && f7 == 7'd1 && en) begin
         r.md   = 1'b1;
         r.mdop = f3;
      end else if (op == 3'b010) begin
         r.il = 1'b1;
      end
      return r;
   endfunction
   function automatic ctl_t mk(input bit [3:0] ac, input bit [1:0] sh, input bit a2, input bit su,
                               input bit lh, input bit lhu, input bit md, input bit [2:0] mdop,
                               input bit il);
      ctl_t r;
      r = '0;
      r.ac = ac; r.sh = sh; r.a2 = a2; r.su = su; r.lh = lh; r.lhu = lhu;
      r.md = md; r.mdop = mdop; r.il = il;
      return r;
   endfunction
   // model: each instance holds at most one op, visible from edge index avail on
   bit   have  [3];
   int   avail [3];
   ctl_t held  [3];
   int   cyc = 0;
   always @(posedge clk or negedge reset_n) begin
      ctl_t c;
      bit   vis, rdy;
      if (!reset_n) begin
         for (int d = 0; d < 3; d++) begin
            have[d] <= 1'b0;
            held[d] <= '0;
         end
      end else begin
         cyc <= cyc + 1;
         for (int d = 0; d < 3; d++) begin
            c   = model_dec(en_of(d), aluop, funct3, funct7);
            vis = have[d] && avail[d] <= cyc;
            rdy = !have[d] || (vis && out_ready);
            if (vis && out_ready) have[d] <= 1'b0;
            if (in_valid && rdy) begin
               have[d]  <= 1'b1;
               held[d]  <= c;
               avail[d] <= cyc + 1 + (c.md ? lat_of(d) - 1 : 0);
            end
         end
      end
   end
   bit   pin_on [3];
   bit   pin_ov [3];
   bit   pin_ir [3];
   ctl_t pin_c  [3];
   int   checks = 0;
   int   errors = 0;
   task automatic chk(input string nm, input int d, input logic [16:0] a, input logic [16:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, d, $time, a, e);
      end
   endtask
   always @(negedge clk) begin
      bit vis;
      for (int d = 0; d < 3; d++) begin
         vis = have[d] && avail[d] <= cyc;
         chk("out_valid", d, 17'(act_ov[d]), 17'(vis));
         chk("in_ready", d, 17'(act_ir[d]), 17'(!have[d] || (vis && out_ready)));
         chk("fields", d, act_c[d], 17'(held[d]));
         if (pin_on[d]) begin
            chk("pin_out_valid", d, 17'(act_ov[d]), 17'(pin_ov[d]));
            chk("pin_in_ready", d, 17'(act_ir[d]), 17'(pin_ir[d]));
            chk("pin_fields", d, act_c[d], 17'(pin_c[d]));
         end
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic pin(input int d, input bit ov, input bit ir, input ctl_t c);
      pin_on[d] = 1'b1;
      pin_ov[d] = ov;
      pin_ir[d] = ir;
      pin_c[d]  = c;
   endtask
   task automatic pin_all(input bit ov, input bit ir, input ctl_t c);
      for (int d = 0; d < 3; d++) pin(d, ov, ir, c);
   endtask
   task automatic chkpt();
      @(negedge clk);
      #1;
      for (int d = 0; d < 3; d++) pin_on[d] = 1'b0;
   endtask
   task automatic op(input logic v, input logic [2:0] a, input logic [2:0] f3, input logic [6:0] f7);
      in_valid = v;
      aluop    = a;
      funct3   = f3;
      funct7   = f7;
   endtask
   initial begin
      ctl_t add_c, div_c, zero_c;
      add_c  = mk(4'b0010, 2'd0, 0, 0, 0, 0, 0, 3'd0, 0);
      div_c  = mk(4'b0000, 2'd0, 0, 0, 0, 0, 1, 3'b100, 0);
      zero_c = '0;
      step();
      step();
      pin_all(0, 1, zero_c);
      chkpt();
      step();
      reset_n = 1'b1;
      op(1, 3'b000, 3'b101, 7'b0100000);
      step();
      in_valid = 1'b0;
      pin_all(1, 1, mk(4'b0010, 2'b10, 1, 0, 0, 0, 0, 3'd0, 0));
      chkpt();
      step();
      op(1, 3'b010, 3'b000, 7'd0);
      step();
      pin_all(1, 1, add_c);
      chkpt();
      op(1, 3'b010, 3'b000, 7'h20);
      step();
      pin_all(1, 1, mk(4'b0110, 2'd0, 0, 0, 0, 0, 0, 3'd0, 0));
      chkpt();
      op(1, 3'b010, 3'b011, 7'd0);
      step();
      pin_all(1, 1, mk(4'b0111, 2'd0, 0, 1, 0, 0, 0, 3'd0, 0));
      chkpt();
      op(1, 3'b100, 3'b101, 7'd0);
      step();
      pin_all(1, 1, mk(4'b0010, 2'd0, 0, 0, 1, 1, 0, 3'd0, 0));
      chkpt();
      in_valid = 1'b0;
      step();
      op(1, 3'b010, 3'b100, 7'd1);
      step();
      op(1, 3'b010, 3'b000, 7'd0);
      pin(0, 0, 0, div_c);
      pin(1, 1, 1, mk(4'b0000, 2'd0, 0, 0, 0, 0, 0, 3'd0, 1));
      pin(2, 1, 1, div_c);
      chkpt();
      step();
      pin(0, 0, 0, div_c);
      pin(1, 1, 1, add_c);
      pin(2, 1, 1, add_c);
      chkpt();
      step();
      pin(0, 0, 0, div_c);
      chkpt();
      step();
      pin(0, 1, 1, div_c);
      chkpt();
      step();
      in_valid = 1'b0;
      pin(0, 1, 1, add_c);
      chkpt();
      step();
      op(1, 3'b010, 3'b000, 7'b0100001);
      step();
      in_valid = 1'b0;
      pin_all(1, 1, mk(4'b0000, 2'd0, 0, 0, 0, 0, 0, 3'd0, 1));
      chkpt();
      step();
      op(1, 3'b000, 3'b100, 7'h15);
      out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      repeat (5) begin
         pin_all(1, 0, mk(4'b1000, 2'd0, 0, 0, 0, 0, 0, 3'd0, 0));
         chkpt();
         step();
      end
      out_ready = 1'b1;
      pin_all(1, 1, mk(4'b1000, 2'd0, 0, 0, 0, 0, 0, 3'd0, 0));
      chkpt();
      step();
      pin_all(0, 1, mk(4'b1000, 2'd0, 0, 0, 0, 0, 0, 3'd0, 0));
      chkpt();
      op(1, 3'b010, 3'b101, 7'd1);
      step();
      in_valid = 1'b0;
      step();
      reset_n = 1'b0;
      pin_all(0, 1, zero_c);
      chkpt();
      step();
      reset_n = 1'b1;
      repeat (5) begin
         pin_all(0, 1, zero_c);
         chkpt();
         step();
      end
      for (int i = 0; i < 3000; i++) begin
         in_valid  = $urandom_range(0, 9) < 7;
         out_ready = $urandom_range(0, 9) < 7;
         case ($urandom_range(0, 3))
            0: aluop = 3'b000;
            1: aluop = 3'b010;
            2: aluop = 3'b100;
            default: aluop = 3'($urandom);
         endcase
         funct3 = 3'($urandom);
         case ($urandom_range(0, 3))
            0: funct7 = 7'd0;
            1: funct7 = 7'h20;
            2: funct7 = 7'd1;
            default: funct7 = 7'($urandom);
         endcase
         reset_n = $urandom_range(0, 299) != 0;
         step();
      end
      in_valid = 1'b0;
      reset_n  = 1'b1;
      step();
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
